minitb_ahb_arbiter: RTL and testbench

MINITB_AHB_ARBITER -- requirements
Module: minitb_ahb_arbiter

---
 rtl/minitb_ahb_arbiter_if.sv | 24 ++
 rtl/minitb_ahb_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_minitb_ahb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minitb_ahb_arbiter_if.sv
// AHB-lite style link bundle used for both arbiter-to-master and
// arbiter-to-slave connections. The "master" modport is the side that issues
// transfers; the "slave" modport is the side that answers them.
interface minitb_ahb_arbiter_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic [dataWidth-1:0] hrdata;

  modport master (
    output htrans, haddr, hwrite, hwdata,
    input  hready, hrdata
  );

  modport slave (
    input  htrans, haddr, hwrite, hwdata,
    output hready, hrdata
  );
endinterface

// File: rtl/minitb_ahb_arbiter.sv
// Two-master round-robin arbiter onto a single AHB-lite slave.
// The address phase is passed through combinationally from the winning master.
// The data phase owner is tracked so that write data can be steered to the
// slave, and so that a read completing while its master is stalled can be held.
// Optional feature: define MINITB_AHB_ARB_BURST_HOLD_EN to let the last winner
// keep the bus under contention for up to 4 consecutive transfers.
//
// Data-phase state:
//   state    | meaning
//   DP_IDLE  | no data phase in flight
//   DP_M0_RD | m0 read data phase in flight
//   DP_M0_WR | m0 write data phase in flight
//   DP_M1_RD | m1 read data phase in flight
//   DP_M1_WR | m1 write data phase in flight
module minitb_ahb_arbiter #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input logic                    hclk,
  input logic                    hresetn,
  minitb_ahb_arbiter_if.slave    m0,
  minitb_ahb_arbiter_if.slave    m1,
  minitb_ahb_arbiter_if.master   s
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic [2:0] {
    DP_IDLE  = 3'd0,
    DP_M0_RD = 3'd1,
    DP_M0_WR = 3'd2,
    DP_M1_RD = 3'd3,
    DP_M1_WR = 3'd4
  } dp_state_t;

  dp_state_t            dp_q;
  dp_state_t            dp_next;

  logic                 req0;
  logic                 req1;
  logic                 gnt_valid;
  logic                 gnt_sel;      // 0 = m0, 1 = m1
  logic                 keep_last;
  logic                 win_write;
  logic                 last_q;       // last winner, 0 = m0, 1 = m1
  logic                 dphase_valid;

  logic                 m0_hready;
  logic                 m1_hready;
  logic                 m0_stall;
  logic                 m1_stall;

  logic [1:0]           hold_valid_q;
  logic [dataWidth-1:0] hold0_q;
  logic [dataWidth-1:0] hold1_q;

  logic [1:0]           s_htrans_c;
  logic [addrWidth-1:0] s_haddr_c;
  logic                 s_hwrite_c;
  logic [dataWidth-1:0] s_hwdata_c;

`ifdef MINITB_AHB_ARB_BURST_HOLD_EN
  logic [1:0]           burst_cnt_q;
`endif

  assign req0         = m0.htrans[1];
  assign req1         = m1.htrans[1];
  assign dphase_valid = (dp_q != DP_IDLE);

  // Grant: sole requester wins; on contention alternate away from the last
  // winner unless a burst-hold streak is still running. The pointer and
  // counter only move on s_hready, so the grant is stable through a stall.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_sel   = 1'b0;
    keep_last = 1'b0;
`ifdef MINITB_AHB_ARB_BURST_HOLD_EN
    // dphase_valid means the previous cycle was a granted transfer by last_q,
    // so an idle cycle or reset breaks the streak.
    keep_last = dphase_valid && (burst_cnt_q != 2'd3);
`endif
    if (req0 && req1) begin
      gnt_sel = keep_last ? last_q : ~last_q;
    end else if (req1) begin
      gnt_sel = 1'b1;
    end
  end

  // Address-phase pass-through from the winner; idle bus when nobody asks.
  always_comb begin
    s_htrans_c = HTRANS_IDLE;
    s_haddr_c  = '0;
    s_hwrite_c = 1'b0;
    win_write  = 1'b0;
    if (gnt_valid) begin
      if (gnt_sel) begin
        s_htrans_c = m1.htrans;
        s_haddr_c  = m1.haddr;
        s_hwrite_c = m1.hwrite;
        win_write  = m1.hwrite;
      end else begin
        s_htrans_c = m0.htrans;
        s_haddr_c  = m0.haddr;
        s_hwrite_c = m0.hwrite;
        win_write  = m0.hwrite;
      end
    end
  end

  // Write data follows the registered data-phase owner.
  always_comb begin
    s_hwdata_c = '0;
    case (dp_q)
      DP_M0_RD, DP_M0_WR: s_hwdata_c = m0.hwdata;
      DP_M1_RD, DP_M1_WR: s_hwdata_c = m1.hwdata;
      default:            s_hwdata_c = '0;
    endcase
  end

  // Next data-phase state: advance only when the slave is ready.
  always_comb begin
    dp_next = dp_q;
    if (s.hready) begin
      if (!gnt_valid) begin
        dp_next = DP_IDLE;
      end else begin
        case ({gnt_sel, win_write})
          2'b00:   dp_next = DP_M0_RD;
          2'b01:   dp_next = DP_M0_WR;
          2'b10:   dp_next = DP_M1_RD;
          default: dp_next = DP_M1_WR;
        endcase
      end
    end
  end

  // Data-phase state register; reset abandons any in-flight data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_q <= DP_IDLE;
    end else begin
      dp_q <= dp_next;
    end
  end

  // Last-winner pointer; reset points at m1 so the first contention goes to m0.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_q <= 1'b1;
    end else if (s.hready && gnt_valid) begin
      last_q <= gnt_sel;
    end
  end

`ifdef MINITB_AHB_ARB_BURST_HOLD_EN
  // Streak counter: consecutive granted transfers by the same master,
  // saturating at 3 so a long uncontended run still yields on contention.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      burst_cnt_q <= 2'd0;
    end else if (s.hready) begin
      if (!gnt_valid) begin
        burst_cnt_q <= 2'd0;
      end else if (dphase_valid && (gnt_sel == last_q)) begin
        if (burst_cnt_q != 2'd3) begin
          burst_cnt_q <= burst_cnt_q + 2'd1;
        end
      end else begin
        burst_cnt_q <= 2'd0;
      end
    end
  end
`endif

  // A requesting master that lost arbitration sees a wait state.
  assign m0_stall  = req0 &&  gnt_sel;
  assign m1_stall  = req1 && !gnt_sel;
  assign m0_hready = m0_stall ? 1'b0 : s.hready;
  assign m1_hready = m1_stall ? 1'b0 : s.hready;

  // Read data that completes while its master is stalled is parked here until
  // that master finally sees hready; it would otherwise be lost.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hold_valid_q <= 2'b00;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      if (s.hready && (dp_q == DP_M0_RD) && m0_stall) begin
        hold0_q         <= s.hrdata;
        hold_valid_q[0] <= 1'b1;
      end else if (m0_hready) begin
        hold_valid_q[0] <= 1'b0;
      end
      if (s.hready && (dp_q == DP_M1_RD) && m1_stall) begin
        hold1_q         <= s.hrdata;
        hold_valid_q[1] <= 1'b1;
      end else if (m1_hready) begin
        hold_valid_q[1] <= 1'b0;
      end
    end
  end

  assign s.htrans  = s_htrans_c;
  assign s.haddr   = s_haddr_c;
  assign s.hwrite  = s_hwrite_c;
  assign s.hwdata  = s_hwdata_c;

  assign m0.hready = m0_hready;
  assign m1.hready = m1_hready;
  assign m0.hrdata = hold_valid_q[0] ? hold0_q : s.hrdata;
  assign m1.hrdata = hold_valid_q[1] ? hold1_q : s.hrdata;

endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// Directed bench for the two-master arbiter: slave-side transfers are checked
// by a monitor against a queue of expected transfers, while handshake and
// read-data behaviour is checked inline.
module tb_minitb_ahb_arbiter;

  localparam logic [1:0] NS = 2'b10;

  typedef struct {
    logic [7:0]  addr;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  logic hclk;
  logic hresetn;

  minitb_ahb_arbiter_if #(.addrWidth(8), .dataWidth(32)) m0_if ();
  minitb_ahb_arbiter_if #(.addrWidth(8), .dataWidth(32)) m1_if ();
  minitb_ahb_arbiter_if #(.addrWidth(8), .dataWidth(32)) s_if ();

  minitb_ahb_arbiter #(.addrWidth(8), .dataWidth(32)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  exp_t exp_q[$];
  exp_t mon_cur;
  logic mon_pend;
  int   checks;
  int   errors;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_m0(input logic [1:0] t, input logic [7:0] a, input logic w, input logic [31:0] d);
    m0_if.htrans = t;
    m0_if.haddr  = a;
    m0_if.hwrite = w;
    m0_if.hwdata = d;
  endtask

  task automatic drive_m1(input logic [1:0] t, input logic [7:0] a, input logic w, input logic [31:0] d);
    m1_if.htrans = t;
    m1_if.haddr  = a;
    m1_if.hwrite = w;
    m1_if.hwdata = d;
  endtask

  // Idle the address phase but leave hwdata for a pending write data phase.
  task automatic idle_m0();
    m0_if.htrans = 2'b00;
    m0_if.haddr  = 8'h00;
    m0_if.hwrite = 1'b0;
  endtask

  task automatic idle_m1();
    m1_if.htrans = 2'b00;
    m1_if.haddr  = 8'h00;
    m1_if.hwrite = 1'b0;
  endtask

  task automatic expect_xfer(input logic [7:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.write = w;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted slave address phase pops one expectation, and the
  // following cycle's write data is compared for write transfers.
  initial begin
    mon_pend = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        mon_pend = 1'b0;
      end else begin
        if (mon_pend) begin
          if (mon_cur.write) chk("mon_hwdata", s_if.hwdata, mon_cur.wdata);
          mon_pend = 1'b0;
        end
        if (s_if.htrans == NS && s_if.hready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got addr %h expected no transfer at %0t", s_if.haddr, $time);
          end else begin
            mon_cur = exp_q.pop_front();
            chk("mon_haddr", 32'(s_if.haddr), 32'(mon_cur.addr));
            chk("mon_hwrite", 32'(s_if.hwrite), 32'(mon_cur.write));
            mon_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    hresetn = 1'b0;
    drive_m0(2'b00, 8'h00, 1'b0, 32'h0);
    drive_m1(2'b00, 8'h00, 1'b0, 32'h0);
    s_if.hready = 1'b1;
    s_if.hrdata = 32'hDEADBEEF;

    // Outputs while held in reset
    #2;
    chk("rst_htrans", 32'(s_if.htrans), 32'h0);
    chk("rst_haddr", 32'(s_if.haddr), 32'h0);
    chk("rst_hwrite", 32'(s_if.hwrite), 32'h0);
    chk("rst_hwdata", s_if.hwdata, 32'h0);
    chk("rst_m0_hready", 32'(m0_if.hready), 32'h1);
    chk("rst_m1_hready", 32'(m1_if.hready), 32'h1);
    chk("rst_m0_hrdata", m0_if.hrdata, 32'hDEADBEEF);
    chk("rst_m1_hrdata", m1_if.hrdata, 32'hDEADBEEF);
    tick();
    tick();
    hresetn = 1'b1;

    // First contention after reset goes to m0, m1 waits one cycle
    drive_m0(NS, 8'h20, 1'b0, 32'h0);
    drive_m1(NS, 8'h30, 1'b0, 32'h0);
    expect_xfer(8'h20, 1'b0, 32'h0);
    expect_xfer(8'h30, 1'b0, 32'h0);
    #1;
    chk("first_gnt_addr", 32'(s_if.haddr), 32'h20);
    chk("first_m0_hready", 32'(m0_if.hready), 32'h1);
    chk("first_m1_hready", 32'(m1_if.hready), 32'h0);
    tick();
    idle_m0();
    #1;
    chk("second_gnt_addr", 32'(s_if.haddr), 32'h30);
    chk("second_m1_hready", 32'(m1_if.hready), 32'h1);
    tick();
    idle_m1();
    tick();

    // Lone write by m0
    drive_m0(NS, 8'h10, 1'b1, 32'hA5);
    expect_xfer(8'h10, 1'b1, 32'hA5);
    #1;
    chk("wr_addr_same_cycle", 32'(s_if.haddr), 32'h10);
    chk("wr_m0_hready_a", 32'(m0_if.hready), 32'h1);
    tick();
    idle_m0();
    #1;
    chk("wr_hwdata_next", s_if.hwdata, 32'hA5);
    chk("wr_m0_hready_d", 32'(m0_if.hready), 32'h1);
    tick();
    tick();

    // Lone m1 read leaves m1 as last winner
    drive_m1(NS, 8'h60, 1'b0, 32'h0);
    expect_xfer(8'h60, 1'b0, 32'h0);
    tick();
    idle_m1();
    tick();

    // Six transfers with both masters requesting continuously
    drive_m0(NS, 8'h40, 1'b0, 32'h0);
    drive_m1(NS, 8'h50, 1'b0, 32'h0);
`ifdef MINITB_AHB_ARB_BURST_HOLD_EN
    expect_xfer(8'h40, 1'b0, 32'h0);
    expect_xfer(8'h40, 1'b0, 32'h0);
    expect_xfer(8'h40, 1'b0, 32'h0);
    expect_xfer(8'h40, 1'b0, 32'h0);
    expect_xfer(8'h50, 1'b0, 32'h0);
    expect_xfer(8'h50, 1'b0, 32'h0);
`else
    for (int i = 0; i < 3; i++) begin
      expect_xfer(8'h40, 1'b0, 32'h0);
      expect_xfer(8'h50, 1'b0, 32'h0);
    end
`endif
    repeat (6) tick();
    idle_m0();
    idle_m1();
    tick();

    // m0 read completes while m0 is stalled behind m1: data must be held
    for (int i = 0; i < 4; i++) begin
      drive_m0(NS, 8'(8'h70 + i), 1'b0, 32'h0);
      expect_xfer(8'(8'h70 + i), 1'b0, 32'h0);
      tick();
    end
    drive_m0(NS, 8'h74, 1'b0, 32'h0);
    drive_m1(NS, 8'h80, 1'b1, 32'h0BADBEEF);
    s_if.hrdata = 32'h11223344;
    expect_xfer(8'h80, 1'b1, 32'h0BADBEEF);
    expect_xfer(8'h74, 1'b0, 32'h0);
    #1;
    chk("hold_gnt_addr", 32'(s_if.haddr), 32'h80);
    chk("hold_m0_hready_lo", 32'(m0_if.hready), 32'h0);
    chk("hold_m1_hready", 32'(m1_if.hready), 32'h1);
    tick();
    idle_m1();
    s_if.hrdata = 32'hCAFEF00D;
    #1;
    chk("hold_m0_hready_hi", 32'(m0_if.hready), 32'h1);
    chk("hold_m0_hrdata", m0_if.hrdata, 32'h11223344);
    chk("hold_m1_hrdata", m1_if.hrdata, 32'hCAFEF00D);
    tick();
    idle_m0();
    #1;
    chk("hold_released", m0_if.hrdata, 32'hCAFEF00D);
    tick();

    // Slave stall for three cycles mid-sequence
    drive_m0(NS, 8'h90, 1'b1, 32'h12345678);
    drive_m1(NS, 8'hA0, 1'b0, 32'h0);
    expect_xfer(8'hA0, 1'b0, 32'h0);
    expect_xfer(8'h90, 1'b1, 32'h12345678);
    #1;
    chk("stall_pre_addr", 32'(s_if.haddr), 32'hA0);
    tick();
    idle_m1();
    s_if.hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_haddr", 32'(s_if.haddr), 32'h90);
      chk("stall_htrans", 32'(s_if.htrans), 32'(NS));
      chk("stall_m0_hready", 32'(m0_if.hready), 32'h0);
      chk("stall_m1_hready", 32'(m1_if.hready), 32'h0);
      tick();
    end
    s_if.hready = 1'b1;
    #1;
    chk("stall_end_m0_hready", 32'(m0_if.hready), 32'h1);
    tick();
    idle_m0();
    #1;
    chk("dphase_hwdata", s_if.hwdata, 32'h12345678);

    // Reset in the middle of the data phase, no clock edge in between
    #1;
    hresetn = 1'b0;
    #1;
    chk("async_rst_hwdata", s_if.hwdata, 32'h0);
    chk("async_rst_htrans", 32'(s_if.htrans), 32'h0);
    chk("async_rst_m0_hready", 32'(m0_if.hready), 32'h1);
    tick();
    tick();
    hresetn = 1'b1;
    drive_m0(NS, 8'hB0, 1'b0, 32'h0);
    drive_m1(NS, 8'hC0, 1'b0, 32'h0);
    expect_xfer(8'hB0, 1'b0, 32'h0);
    expect_xfer(8'hC0, 1'b0, 32'h0);
    #1;
    chk("post_rst_gnt_addr", 32'(s_if.haddr), 32'hB0);
    chk("post_rst_m1_hready", 32'(m1_if.hready), 32'h0);
    tick();
    idle_m0();
    tick();
    idle_m1();
    repeat (3) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
